// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead
// byte FIFO drained with a valid/ready handshake; sticky error flags cleared by err_clr.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_AW      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_rx,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [FIFO_AW:0] fifo_count,
    input  logic             err_clr,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    logic sync1_reg, rx_s_reg, rx_prev_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg   <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync1_reg   <= ser_rx;
            rx_s_reg    <= sync1_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    logic [2:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tick;
    logic          stop_tick;
    logic          push_req;
    logic          frame_set;

    assign tick      = (cnt_reg == '0);
    assign stop_tick = (state_reg == S_STOP) && tick;
    assign frame_set = stop_tick && !rx_s_reg;

`ifdef UART_RX_PARITY_EN
    logic bad_reg;
    logic parity_set;
    logic parity_err_reg;

    assign parity_set = (state_reg == S_PARITY) && tick && (rx_s_reg != ^shift_reg);
    assign push_req   = stop_tick && rx_s_reg && !bad_reg;
`else
    assign push_req   = stop_tick && rx_s_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
`ifdef UART_RX_PARITY_EN
            bad_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (rx_prev_reg && !rx_s_reg) begin
                        cnt_reg   <= HALF_LOAD;
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        // A start bit that is high again at mid-bit was a glitch
                        if (!rx_s_reg) begin
                            cnt_reg     <= FULL_LOAD;
                            bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                            bad_reg     <= 1'b0;
`endif
                            state_reg   <= S_DATA;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift_reg   <= {rx_s_reg, shift_reg[7:1]};
                        cnt_reg     <= FULL_LOAD;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= S_PARITY;
`else
                            state_reg <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        bad_reg   <= parity_set;
                        cnt_reg   <= FULL_LOAD;
                        state_reg <= S_STOP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick) state_reg <= S_IDLE;
                    else      cnt_reg   <= cnt_reg - 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Show-ahead FIFO: head byte is read combinationally from the array
    logic [7:0]         mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg;
    logic               full, pop, push, overrun_set;
    logic               overrun_reg, frame_err_reg;

    assign full        = (count_reg == DEPTH_CNT);
    assign pop         = rd_valid && rd_ready;
    assign push        = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= shift_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as err_clr takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            overrun_reg   <= overrun_set | (overrun_reg & ~err_clr);
            frame_err_reg <= frame_set | (frame_err_reg & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_set | (parity_err_reg & ~err_clr);
`endif
        end
    end

    assign rd_valid   = (count_reg != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr_reg] : 8'h00;
    assign fifo_count = count_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized frames
// checked against a queue-based model of the received byte stream.
module tb_uart_rx_fifo;
    localparam int C     = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Negedge index (from the start-bit fall) at which rd_valid is first seen high:
    // 2 sync cycles + C/2 to start sample + (NB-1)*C to stop sample + 1 cycle.
    localparam int LAT = 2 + C / 2 + (NB - 1) * C + 1;

    logic          clk = 1'b0;
    logic          reset, ser_rx, rd_ready, err_clr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   fifo_count;
    logic          overrun, frame_err, parity_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] model_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .err_clr(err_clr),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ser_rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drives one whole frame, one bit per C cycles, starting at the next negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par,
                              input logic pop_at_stop, output int first_valid, output logic fe_at_lat);
        logic [NB-1:0] fr;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
        fr[9] = (^b) ^ flip_par;
`endif
        fr[NB-1] = stop_bit;
        first_valid = -1;
        fe_at_lat = 1'b0;
        $display("frame byte=%02h stop=%0d flip_par=%0d", b, stop_bit, flip_par);
        for (int c = 0; c < NB * C; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (c == LAT) fe_at_lat = frame_err;
            if (pop_at_stop) rd_ready = (c == LAT - 1);
            if (c % C == 0) begin
                ser_rx = fr[0];
                fr = fr >> 1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ser_rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if ({overrun, frame_err, parity_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {overrun, frame_err, parity_err}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int fv; logic fe;
        do_reset();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, fv, fe);
        total++; if (fv !== LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", fv, LAT); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", rd_data); end
        total++; if (fifo_count !== (AW + 1)'(1)) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        total++; if (rd_valid !== 1'b0 || fifo_count !== '0) begin
            bad++; $display("FAIL single_pop: got valid=%b count=%0d want 0/0", rd_valid, fifo_count); end
    endtask

    task automatic test_glitch();
        int fv; logic fe; logic [7:0] b;
        do_reset();
        ser_rx = 1'b0;
        repeat (2) @(negedge clk);
        ser_rx = 1'b1;
        repeat (3 * C) @(negedge clk);
        total++; if (rd_valid !== 1'b0 || fifo_count !== '0) begin
            bad++; $display("FAIL glitch_nobyte: got valid=%b count=%0d want 0/0", rd_valid, fifo_count); end
        total++; if ({overrun, frame_err, parity_err} !== 3'b000) begin
            bad++; $display("FAIL glitch_flags: got %b want 000", {overrun, frame_err, parity_err}); end
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0, 1'b0, fv, fe);
        total++; if (rd_valid !== 1'b1 || rd_data !== b) begin
            bad++; $display("FAIL glitch_next: got valid=%b data=%h want 1/%h", rd_valid, rd_data, b); end
    endtask

    task automatic test_overrun();
        int fv; logic fe;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, fv, fe);
        total++; if (fifo_count !== (AW + 1)'(DEPTH)) begin bad++; $display("FAIL overrun_count: got %0d want %0d", fifo_count, DEPTH); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                bad++; $display("FAIL overrun_read%0d: got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, 8'(i)); end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL overrun_empty: got %b want 0", rd_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_frame_err();
        int fv; logic fe;
        do_reset();
        err_clr = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, fv, fe);
        err_clr = 1'b0;
        ser_rx = 1'b1;
        total++; if (fe !== 1'b1) begin bad++; $display("FAIL frame_set_wins: got %b want 1", fe); end
        repeat (C) @(negedge clk);
        total++; if (frame_err !== 1'b1 || fifo_count !== '0) begin
            bad++; $display("FAIL frame_sticky: got fe=%b count=%0d want 1/0", frame_err, fifo_count); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_clear: got %b want 0", frame_err); end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, fv, fe);
        total++; if (rd_data !== 8'h55 || fifo_count !== (AW + 1)'(1) || frame_err !== 1'b0) begin
            bad++; $display("FAIL frame_next: got data=%h count=%0d fe=%b want 55/1/0", rd_data, fifo_count, frame_err); end
    endtask

    task automatic test_full_push_pop();
        int fv; logic fe;
        logic [7:0] vals[DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            vals[i] = 8'($urandom);
            send_frame(vals[i], 1'b1, 1'b0, 1'b0, fv, fe);
        end
        send_frame(8'h77, 1'b1, 1'b0, 1'b1, fv, fe);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fullpp_overrun: got %b want 0", overrun); end
        total++; if (fifo_count !== (AW + 1)'(DEPTH)) begin bad++; $display("FAIL fullpp_count: got %0d want %0d", fifo_count, DEPTH); end
        rd_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == DEPTH) ? 8'h77 : vals[i];
            total++; if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
                bad++; $display("FAIL fullpp_read%0d: got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, exp_b); end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int fv; logic fe;
        do_reset();
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, fv, fe);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, fv, fe);
        ser_rx = 1'b1;
        repeat (C) @(negedge clk);
        // start bit plus four low data bits of 0xF0
        ser_rx = 1'b0;
        repeat (5 * C) @(negedge clk);
        reset = 1'b1;
        ser_rx = 1'b1;
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== '0) begin
            bad++; $display("FAIL midreset_fifo: got valid=%b data=%h count=%0d want 0/00/0", rd_valid, rd_data, fifo_count); end
        total++; if ({overrun, frame_err, parity_err} !== 3'b000) begin
            bad++; $display("FAIL midreset_flags: got %b want 000", {overrun, frame_err, parity_err}); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3 * C) @(negedge clk);
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL midreset_nobyte: got %0d want 0", fifo_count); end
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, fv, fe);
        total++; if (rd_data !== 8'h12 || fifo_count !== (AW + 1)'(1)) begin
            bad++; $display("FAIL midreset_next: got data=%h count=%0d want 12/1", rd_data, fifo_count); end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
`ifdef UART_RX_PARITY_EN
        send_frame(8'h12, 1'b1, 1'b1, 1'b0, fv, fe);
        @(negedge clk);
        total++; if (parity_err !== 1'b1 || fifo_count !== '0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL parity_bad: got pe=%b count=%0d fe=%b want 1/0/0", parity_err, fifo_count, frame_err); end
`endif
    endtask

    task automatic test_back_to_back();
        int fv; logic fe; logic exp_fe;
        do_reset();
        exp_fe = 1'b0;
        for (int batch = 0; batch < 4; batch++) begin
            int n;
            int guard;
            n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++) begin
                logic [7:0] b;
                logic bad_stop;
                b = 8'($urandom);
                bad_stop = ($urandom_range(0, 5) == 0);
                send_frame(b, !bad_stop, 1'b0, 1'b0, fv, fe);
                if (bad_stop) begin
                    exp_fe = 1'b1;
                    ser_rx = 1'b1;
                    repeat (C) @(negedge clk);
                end else begin
                    model_q.push_back(b);
                end
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, C)) @(negedge clk);
            end
            total++; if (fifo_count !== (AW + 1)'(model_q.size())) begin
                bad++; $display("FAIL b2b_count%0d: got %0d want %0d", batch, fifo_count, model_q.size()); end
            total++; if (frame_err !== exp_fe || overrun !== 1'b0) begin
                bad++; $display("FAIL b2b_flags%0d: got fe=%b ov=%b want %b/0", batch, frame_err, overrun, exp_fe); end
            guard = 0;
            while (model_q.size() > 0 && guard < 400) begin
                @(negedge clk);
                guard++;
                total++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
                    bad++; $display("FAIL b2b_read%0d: got valid=%b data=%h want 1/%h", batch, rd_valid, rd_data, model_q[0]); end
                rd_ready = 1'($urandom_range(0, 1));
                if (rd_ready) void'(model_q.pop_front());
            end
            @(negedge clk);
            rd_ready = 1'b0;
            total++; if (model_q.size() != 0 || rd_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_drain%0d: got left=%0d valid=%b want 0/0", batch, model_q.size(), rd_valid);
                model_q.delete();
            end
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            exp_fe = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; ser_rx = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_full_push_pop();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end for the `riscv_i` core. It sits between the board `Uart_Rx` pin and the CPU's receive register interface. The block synchronises `ser_rx` and deserialises 8N1 frames (8E1 when parity is compiled in) using a clocks-per-bit counter. Received bytes are buffered in a show-ahead FIFO that the CPU drains with a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, 434, `clk` cycles per serial bit; legal minimum 4.
- `FIFO_AW`, 3, FIFO address width; depth = 2**FIFO_AW (default 8).
- `clk`  in  1  block clock, the same clock that drives `riscv_i`.
- `reset`  in  1  asynchronous, active-high reset.
- `ser_rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `rd_data`  out  8  head-of-FIFO byte; valid only while `rd_valid`=1.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `fifo_count`  out  FIFO_AW+1  current occupancy, 0..2**FIFO_AW.
- `err_clr`  in  1  clears the sticky error flags.
- `overrun`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky flag: the stop bit was sampled low.
- `parity_err`  out  1  sticky flag: parity mismatch; tied 0 without `UART_RX_PARITY_EN`.

## Operation
- **Synchroniser:** `ser_rx` passes through two flops, both reset to 1, giving `rx_s`. All logic uses `rx_s` only.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP.
- **IDLE:** a 1→0 transition on `rx_s` loads the bit counter with CLKS_PER_BIT/2−1 (integer division) and moves to START.
- **START:** at counter expiry, sample `rx_s`.
  - If 0: reload the counter with CLKS_PER_BIT−1, clear the bit index, go to DATA.
  - If 1 (glitch): return to IDLE silently.
- **DATA:** at each counter expiry, shift `rx_s` into the shift register, LSB first, and reload the counter.
  - After bit index 7, go to PARITY if compiled in, otherwise STOP.
- **PARITY:** sample one bit and compare it with the XOR of the 8 data bits (even parity). A mismatch marks the frame bad and sets `parity_err`.
- **STOP:** sample `rx_s`.
  - If 1 and the frame is not bad: push the byte to the FIFO.
  - If 0: set `frame_err` and discard the byte.
  - In either case return to IDLE.
  - A line held low (break) generates no new frame until a fresh 1→0 edge.
- **FIFO:** show-ahead; `rd_data` = mem[rd_ptr].
  - Pop when `rd_valid && rd_ready`.
  - Push when full and no pop in the same cycle: byte dropped, `overrun` set.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - Pointers wrap modulo 2**FIFO_AW.
  - `fifo_count` increments on push-only, decrements on pop-only, and is unchanged otherwise.
- **Error flags:** set by their events and cleared by `err_clr`. If set and clear occur in the same cycle, set wins.
- **Reset values:**
  - `reset`=1 at any time, including mid-frame, forces FSM to IDLE, pointers to 0, `fifo_count`=0, `rd_valid`=0, `rd_data`=0, all error flags 0, synchroniser to 1.
  - A frame in progress at reset is lost.
  - After reset release, the receiver waits for a fresh falling edge.

## Timing
- The start edge is seen 2 cycles after the `ser_rx` fall (synchroniser delay).
- The start-bit sample is taken CLKS_PER_BIT/2 cycles after the edge is detected.
- Each subsequent sample follows the previous one by exactly CLKS_PER_BIT cycles.
- Byte latency: the stop-bit sample cycle writes the FIFO; `rd_valid` rises on the next cycle. `rd_data` is stable from that cycle.
- Pop: `rd_data`/`rd_valid` update one cycle after the accepting edge. The back-to-back pop throughput is 1 byte/cycle.
- Minimum frame is 10 bit times (11 with parity). Consecutive frames with no idle gap must be received correctly.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1, the PARITY state exists, and `parity_err` is live.
- Not defined: frame is 8N1, the PARITY state is removed, and `parity_err` is constant 0.

## Test plan
- **Single byte:** CLKS_PER_BIT=8, send 0xA5 in 8N1 → `rd_valid` rises 1 cycle after the stop sample with `rd_data`=0xA5 and `fifo_count`=1. Pulse `rd_ready` → `rd_valid`=0, count=0.
- **Glitch rejection:** hold `ser_rx` low for 2 cycles then high → no byte, no flags, FSM back in IDLE.
- **Overrun:** send 9 bytes 0x00..0x08 with `rd_ready`=0, FIFO_AW=3 → count=8, `overrun`=1, data read out = 0x00..0x07. `err_clr` → `overrun`=0.
- **Framing error:** send 0x3C with the stop bit low → no push, `frame_err`=1. A following valid 0x55 is received correctly.
- **Full with simultaneous push/pop:** FIFO full, `rd_ready`=1 in the stop-sample cycle of 0x77 → `overrun`=0, count stays 8, 0x77 is the last byte read.
- **Reset mid-frame:** assert `reset` after 4 data bits of 0xF0 → all outputs at reset values, no byte. The next frame 0x12 is received. With `UART_RX_PARITY_EN`, 0x12 sent with a wrong parity bit → `parity_err`=1 and no push.
